result_wb_arbiter: RTL
======================

// Module: result_wb_arbiter
// PURPOSE
//  Merges result uops from two execution units (port 0: integer/ALU, port 1: FP multiply) onto one
//  writeback/result bus. Per-port FIFOs absorb collisions because FUs cannot stall mid-pipe.
//  The oldest (by sqN) valid head wins. Branch mispredicts squash younger buffered results.
//  Sits between the FU output registers and the register-file write / ROB completion logic.
// PARAMETERS
//  DEPTH         4   entries per port FIFO; power of two, >=2
//  STALL_MARGIN  1   in-flight FU slots; OUT_fullN asserts when free entries <= STALL_MARGIN
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous active-high reset
//  IN_branch  in   76  branch bus; [0]=mispredict valid, [43:37]=branch sqN
//  IN_uop0    in   88  result uop port 0; [87:56]=result, [55:49]=tagDst, [48:44]=nmDst,
//                      [43:37]=sqN, [36:5]=pc, [4:2]=flags, [1]=compressed, [0]=valid
//  IN_uop1    in   88  result uop port 1, same layout
//  OUT_uop    out  88  registered writeback uop, same layout
//  OUT_full0  out  1   back-pressure to issue for port-0 FU
//  OUT_full1  out  1   back-pressure to issue for port-1 FU
// BEHAVIOUR
//  - Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
//  - Reset: OUT_uop[0]=0 and OUT_full0/1=0. All FIFO entry valids, pointers and counts are 0.
//    OUT_uop[87:1] is don't-care. Reset mid-operation discards all buffered results.
//  - Younger(x,b) := $signed(x - b) > 0, computed on 7-bit sqN with a 7-bit signed difference,
//    so wrap-around is handled.
//  - Enqueue: IN_uopN[0]=1 writes the entry at the tail on the clock edge, unless the uop is
//    squashed by the same-cycle branch (IN_branch[0] && Younger(sqN, branch sqN)).
//    A squashed uop is dropped and never stored.
//  - Flush: on IN_branch[0], every stored entry with Younger(sqN, branch sqN) has its valid bit
//    cleared in place. It is not compacted. A flushed entry still occupies its slot until popped.
//  - Head handling: an invalid head is popped with no output; each port can pop one per cycle.
//  - Arbitration among valid, non-squashed heads:
//    - only one valid -> it wins;
//    - both valid -> port 0 wins if $signed(sqN0 - sqN1) <= 0, else port 1.
//    - The winner is popped and registered into OUT_uop with [0]=1. The loser stays.
//  - If no winner exists, OUT_uop[0]<=0 and the other fields hold their values.
//  - Output squash: a registered OUT_uop already valid at the edge is not retracted. The
//    consumer filters it against the branch bus. A head squashed in the same cycle as its
//    selection is not output.
//  - Latency (no bypass): an uop enqueued at edge N appears on OUT_uop after edge N+1, at the
//    earliest.
//  - Count update: count' = count + enq - pop.
//  - OUT_fullN is registered: OUT_fullN = (DEPTH - count') <= STALL_MARGIN.
//  - Full: an enqueue while count==DEPTH, before pop, is a protocol violation. The entry is
//    dropped and a simulation-only $error is raised. A same-cycle pop does not make room.
//  - Pointers wrap modulo DEPTH (log2(DEPTH)-bit pointers, (log2(DEPTH)+1)-bit count).
// CONFIGURATION
//  - Macro WB_BYPASS_EN:
//    - defined: an incoming valid, non-squashed uop on a port whose FIFO is empty (count==0)
//      may go directly to OUT_uop on the same edge (latency 1).
//    - The bypass uop competes as that port's head under the same oldest-first rule.
//    - If it loses, it is enqueued normally.
//    - undefined: all uops pass through the FIFO; minimum latency is 2 edges.
// TESTING
//  1. Reset: assert rst 2 cycles with valid inputs -> OUT_uop[0]=0, OUT_full0/1=0 for the
//     cycle after release.
//  2. Single: port0 sqN=5, result=0x3F800000 -> OUT_uop valid with identical fields, 2 edges
//     later (1 edge with WB_BYPASS_EN).
//  3. Collision: port0 sqN=9 and port1 sqN=7 in the same cycle -> sqN=7 is output first,
//     sqN=9 on the next cycle.
//  4. Wrap: port0 sqN=126, port1 sqN=1 together -> 126 is output first (older across wrap).
//  5. Flush: buffer port1 sqN=10,12,14, then branch valid with branch sqN=11
//     -> only 10 is output; 12 and 14 are never output; count returns to 0.
//  6. Back-pressure: DEPTH=4, STALL_MARGIN=1, stream port0 while port1 keeps winning
//     -> OUT_full0=1 after count reaches 3; no entry is lost when issue honours OUT_full0.

Source files
------------

// File: rtl/result_wb_arbiter_if.sv
// result_wb_arbiter_if: result/branch buses between the two FU output stages,
// the writeback arbiter and the issue back-pressure logic.
// Uop layout (88b): [87:56]=result [55:49]=tagDst [48:44]=nmDst [43:37]=sqN
//                   [36:5]=pc [4:2]=flags [1]=compressed [0]=valid
// Branch bus (76b): [0]=mispredict valid, [43:37]=branch sqN
interface result_wb_arbiter_if;
   logic [75:0] IN_branch;
   logic [87:0] IN_uop0;
   logic [87:0] IN_uop1;
   logic [87:0] OUT_uop;
   logic        OUT_full0;
   logic        OUT_full1;

   // FU / branch side drives results, sees writeback and back-pressure
   modport master (
      output IN_branch, IN_uop0, IN_uop1,
      input  OUT_uop, OUT_full0, OUT_full1
   );

   // arbiter side
   modport slave (
      input  IN_branch, IN_uop0, IN_uop1,
      output OUT_uop, OUT_full0, OUT_full1
   );
endinterface

// File: rtl/result_wb_arbiter.sv
// result_wb_arbiter: merges result uops from two FUs (port 0 ALU, port 1 FP mul)
// onto one registered writeback bus. Each port has a small FIFO because FUs
// cannot stall mid-pipe; the oldest valid head (by 7-bit wrapping sqN) wins,
// port 0 on a tie. Mispredicts clear younger buffered entries in place.
// Optional macro WB_BYPASS_EN: an incoming uop on an empty port may compete
// directly and reach OUT_uop on its arrival edge.

// Per-port result FIFO with in-place squash and registered almost-full.
module wb_port_fifo #(
   parameter int DEPTH        = 4,
   parameter int STALL_MARGIN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [87:0] in_uop,
   input  logic        br_vld,
   input  logic [6:0]  br_sqn,
   input  logic        win,
   output logic [87:0] head_uop,
   output logic        head_ok,
   output logic        full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][87:0] mem;
   logic [DEPTH-1:0]       ent_vld;
   logic [PW-1:0]          rd_ptr, wr_ptr;
   logic [CW-1:0]          count, count_nxt;
   logic                   enq_req, enq, pop, stored_ok, byp;

   // x is younger than b when the 7-bit wrapped difference is strictly positive
   function automatic logic younger(input logic [6:0] x, input logic [6:0] b);
      logic [6:0] d;
      d = x - b;
      return !d[6] && (d != 7'd0);
   endfunction

   assign enq_req   = in_uop[0] && !(br_vld && younger(in_uop[43:37], br_sqn));
   // a head squashed this very cycle is treated as invalid and dropped
   assign stored_ok = (count != '0) && ent_vld[rd_ptr]
                      && !(br_vld && younger(mem[rd_ptr][43:37], br_sqn));
`ifdef WB_BYPASS_EN
   assign byp       = enq_req && (count == '0);
`else
   assign byp       = 1'b0;
`endif
   assign head_ok   = byp || stored_ok;
   assign head_uop  = byp ? in_uop : mem[rd_ptr];
   // invalid heads drain one per cycle without producing output
   assign pop       = (count != '0) && (!stored_ok || win);
   // a full FIFO refuses the write even if the head pops this cycle
   assign enq       = enq_req && !(byp && win) && (count != CW'(DEPTH));
   assign count_nxt = count + CW'(enq) - CW'(pop);

   // pointers, entry valids (flush in place), count and registered full flag
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_vld <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         full    <= 1'b0;
      end else begin
         if (br_vld)
            for (int i = 0; i < DEPTH; i++)
               if (younger(mem[i][43:37], br_sqn)) ent_vld[i] <= 1'b0;
         if (pop) begin
            ent_vld[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + PW'(1);
         end
         if (enq) begin
            ent_vld[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         count <= count_nxt;
         full  <= (CW'(DEPTH) - count_nxt) <= CW'(STALL_MARGIN);
      end
   end

   // payload storage; contents are qualified by ent_vld and count, so no reset
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= in_uop;
   end

`ifndef SYNTHESIS
   // issue must honour the full flag; a write into a full FIFO loses a result
   always_ff @(posedge clk) begin
      if (!rst && enq_req && (count == CW'(DEPTH)))
         $error("wb_port_fifo: enqueue into full FIFO, uop dropped");
   end
`endif
endmodule

module result_wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STALL_MARGIN = 1
) (
   input logic                clk,
   input logic                rst,
   result_wb_arbiter_if.slave wb
);
   localparam int NUM_PORTS = 2;

   logic [NUM_PORTS-1:0][87:0] in_uop, head_uop;
   logic [NUM_PORTS-1:0]       head_ok, win, full;
   logic [87:0]                out_q;
   logic [6:0]                 age_d;
   logic                       unused_br;

   assign in_uop[0] = wb.IN_uop0;
   assign in_uop[1] = wb.IN_uop1;
   // only the valid bit and branch sqN of the branch bus matter here
   assign unused_br = ^{wb.IN_branch[75:44], wb.IN_branch[36:1]};

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      wb_port_fifo #(.DEPTH(DEPTH), .STALL_MARGIN(STALL_MARGIN)) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .in_uop   (in_uop[p]),
         .br_vld   (wb.IN_branch[0]),
         .br_sqn   (wb.IN_branch[43:37]),
         .win      (win[p]),
         .head_uop (head_uop[p]),
         .head_ok  (head_ok[p]),
         .full     (full[p])
      );
   end

   assign age_d = head_uop[0][43:37] - head_uop[1][43:37];

   // oldest-first pick; port 0 wins when its sqN is older or equal
   always_comb begin
      win = '0;
      if (head_ok[0] && (!head_ok[1] || age_d[6] || (age_d == 7'd0)))
         win[0] = 1'b1;
      else if (head_ok[1])
         win[1] = 1'b1;
   end

   // writeback register; payload holds when idle, only the valid bit drops
   always_ff @(posedge clk) begin
      if (rst)
         out_q <= '0;
      else if (win[0])
         out_q <= {head_uop[0][87:1], 1'b1};
      else if (win[1])
         out_q <= {head_uop[1][87:1], 1'b1};
      else
         out_q[0] <= 1'b0;
   end

   assign wb.OUT_uop   = out_q;
   assign wb.OUT_full0 = full[0];
   assign wb.OUT_full1 = full[1];
endmodule
